// File: rtl/vga_timing_decoder.sv
// ---------------------------------------------------------------------------
// vga_timing_decoder
//
// Recovers pixel column / line coordinates from a pair of active-low VGA sync
// inputs. Free-running counters are aligned to the falling edges of HS and VS;
// once two consecutive VS falls agree with the counters the block declares
// lock and from then on only checks that the sync edges keep arriving exactly
// where the counters predict.
//
// Ports
//   CLK       in   pixel clock, rising edge
//   RST       in   asynchronous reset, active-high
//   HS        in   horizontal sync, active-low
//   VS        in   vertical sync, active-low, changes only at line start
//   x         out  recovered pixel column (registered)
//   y         out  recovered line number (registered)
//   de        out  data enable: locked and inside the visible area
//   locked    out  high while state is LOCKED
//   sync_err  out  one-cycle pulse, registered, on any sync mismatch or
//                  missing edge (visible the cycle after the offending edge)
// ---------------------------------------------------------------------------
module vga_timing_decoder #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_TOTAL   = 525
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HS,
    input  logic       VS,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       locked,
    output logic       sync_err
);

    // Column at which the HS fall is expected, and the value loaded on a
    // reload so that the counter matches the source from the next cycle.
    localparam logic [9:0] H_EDGE = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_LOAD = 10'(H_VISIBLE + H_FP + 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    // The VS fall coincides with column 0 of this line.
    localparam logic [9:0] V_EDGE = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state;
    logic       hs_d;
    logic       vs_d;
    logic       vs_seen;
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    logic       hs_fall;
    logic       vs_fall;
    logic       h_mark;
    logic       v_mark;
    logic       hs_bad;
    logic       vs_bad;
    logic       lock_err;
    logic       line_end;
    logic [9:0] hcnt_inc;
    logic [9:0] vcnt_inc;

    assign hs_fall  = hs_d & ~HS;
    assign vs_fall  = vs_d & ~VS;

    // Positions where a locked stream must show its sync edges.
    assign h_mark   = (hcnt == H_EDGE);
    assign v_mark   = (vcnt == V_EDGE) && (hcnt == 10'd0);

    assign hs_bad   = hs_fall & ~h_mark;
    assign vs_bad   = vs_fall & ~v_mark;

    // Both edges are judged in the same cycle; any single fault breaks lock.
    assign lock_err = hs_bad | (h_mark & ~hs_fall) |
                      vs_bad | (v_mark & ~vs_fall);

    // ">=" keeps the counters in range even if a reload value were ever
    // configured past the end of the line/frame.
    assign line_end = (hcnt >= H_LAST);
    assign hcnt_inc = line_end ? 10'd0 : hcnt + 10'd1;
    assign vcnt_inc = (vcnt >= V_LAST) ? 10'd0 : vcnt + 10'd1;

    assign x  = hcnt;
    assign y  = vcnt;
    assign de = locked && (hcnt < H_VIS) && (vcnt < V_VIS);

    // Counter defaults are assigned first; reloads later in the same block
    // override them, which gives reloads priority over the increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= SEARCH;
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            vs_seen  <= 1'b0;
            hcnt     <= 10'd0;
            vcnt     <= 10'd0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            hs_d     <= HS;
            vs_d     <= VS;
            sync_err <= 1'b0;

            // Counters stay parked at 0 until the first HS fall is seen.
            if (state != SEARCH) begin
                hcnt <= hcnt_inc;
                if (line_end) begin
                    vcnt <= vcnt_inc;
                end
            end

            case (state)
                SEARCH: begin
                    if (hs_fall) begin
                        hcnt    <= H_LOAD;
                        vs_seen <= 1'b0;
                        state   <= ACQUIRE;
                    end
                end

                ACQUIRE: begin
                    if (vs_fall) begin
                        if (!vs_seen) begin
                            vcnt    <= V_EDGE;
                            vs_seen <= 1'b1;
                        end else if (v_mark) begin
                            // A bad HS edge in the same cycle vetoes the lock.
                            if (!hs_bad) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            vcnt     <= V_EDGE;
                            sync_err <= 1'b1;
                        end
                    end
                    if (hs_bad) begin
                        hcnt     <= H_LOAD;
                        vs_seen  <= 1'b0;
                        sync_err <= 1'b1;
                    end
                end

                LOCKED: begin
                    if (lock_err) begin
                        sync_err <= 1'b1;
                        locked   <= 1'b0;
                        vs_seen  <= 1'b0;
                        state    <= ACQUIRE;
                        if (hs_fall) begin
                            hcnt <= H_LOAD;
                        end
                    end
                end

                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_decoder
//
// Directed bench for vga_timing_decoder using a scaled-down raster so that
// several full frames fit in a short run:
//   32 pixels/line (16 visible, front porch 4, HS low on columns 20..25)
//   20 lines/frame (12 visible, front porch 2, VS low on lines 14..15)
// Hand-derived constants for these parameters:
//   HS fall column = 20, hcnt reload value = 21, VS reload line = 14,
//   de-high cycles per frame = 16 * 12 = 192.
// ---------------------------------------------------------------------------
module tb_vga_timing_decoder;

    localparam int HV  = 16;
    localparam int HFP = 4;
    localparam int HT  = 32;
    localparam int HSW = 6;
    localparam int VV  = 12;
    localparam int VFP = 2;
    localparam int VT  = 20;
    localparam int VSW = 2;
    localparam int HE  = 20;   // column of HS fall
    localparam int VE  = 14;   // line of VS fall

    logic       CLK;
    logic       RST;
    logic       HS;
    logic       VS;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       locked;
    logic       sync_err;

    int n_tests;
    int n_fail;

    // Reference generator state
    int gcol;
    int gline;
    int del_line;
    bit vs_sup;
    bit was_vsfall;

    int de_a;
    int de_b;
    int de_c;
    int de_d;

    vga_timing_decoder #(
        .H_VISIBLE (HV),
        .H_FP      (HFP),
        .H_TOTAL   (HT),
        .V_VISIBLE (VV),
        .V_FP      (VFP),
        .V_TOTAL   (VT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .HS       (HS),
        .VS       (VS),
        .x        (x),
        .y        (y),
        .de       (de),
        .locked   (locked),
        .sync_err (sync_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive sync for the current generator position, clock once, sample 1ns
    // after the edge, then advance the generator so gcol/gline describe the
    // column/line the DUT should now be reporting.
    task automatic tick();
        int d;
        d = (gline == del_line) ? 3 : 0;
        HS = (gcol >= HE + d && gcol < HE + d + HSW) ? 1'b0 : 1'b1;
        VS = (!vs_sup && gline >= VE && gline < VE + VSW) ? 1'b0 : 1'b1;
        was_vsfall = !vs_sup && gline == VE && gcol == 0;
        @(posedge CLK);
        #1;
        if (gcol == HT - 1) begin
            if (gline == del_line) del_line = -1;
            if (gline == VE + VSW - 1) vs_sup = 1'b0;
            gcol  = 0;
            gline = (gline == VT - 1) ? 0 : gline + 1;
        end else begin
            gcol++;
        end
    endtask

    task automatic run_until(input string tag, input int l, input int c);
        int n;
        n = 0;
        while (!(gline == l && gcol == c) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk({tag, "_timeout"}, n, 0);
    endtask

    // Waits for two real VS falls: lock must not be up after the first and
    // must rise exactly on the cycle after the second.
    task automatic wait_lock(input string tag);
        int   nvs;
        logic prev;
        bit   done;
        nvs  = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            prev = locked;
            tick();
            if (was_vsfall) begin
                nvs++;
                if (nvs == 1) begin
                    chk({tag, "_first_vs"}, int'(locked), 0);
                end else begin
                    chk({tag, "_pre"}, int'(prev), 0);
                    chk({tag, "_rise"}, int'(locked), 1);
                    done = 1'b1;
                end
            end
        end
        if (!done) chk({tag, "_timeout"}, nvs, 2);
    endtask

    task automatic track(input string tag, input int n, output int de_cnt);
        int mism;
        int serr;
        int unl;
        int deerr;
        logic de_exp;
        mism = 0; serr = 0; unl = 0; deerr = 0; de_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (int'(x) != gcol || int'(y) != gline) mism++;
            if (sync_err) serr++;
            if (!locked) unl++;
            de_exp = (gcol < HV) && (gline < VV);
            if (de !== de_exp) deerr++;
            if (de) de_cnt++;
            if (gcol == 15 && gline == 0)  de_a = int'(de);
            if (gcol == 16 && gline == 0)  de_b = int'(de);
            if (gcol == 0  && gline == 12) de_c = int'(de);
            if (gcol == 15 && gline == 11) de_d = int'(de);
        end
        chk({tag, "_xy_mism"}, mism, 0);
        chk({tag, "_sync_err"}, serr, 0);
        chk({tag, "_unlocked"}, unl, 0);
        chk({tag, "_de_err"}, deerr, 0);
    endtask

    initial begin
        int nz;
        int dc;
        n_tests  = 0;
        n_fail   = 0;
        gcol     = 0;
        gline    = 0;
        del_line = -1;
        vs_sup   = 1'b0;
        de_a = -1; de_b = -1; de_c = -1; de_d = -1;

        // Reset with HS held low
        RST = 1'b1;
        HS  = 1'b0;
        VS  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sync_err", int'(sync_err), 0);

        // Release with HS still low: no edge may be seen
        RST = 1'b0;
        nz = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            if (x != 10'd0 || y != 10'd0 || locked) nz++;
        end
        chk("hs_low_hold", nz, 0);

        // HS rises at column 0, falls at column 20
        for (int i = 0; i < HE; i++) tick();
        chk("search_hold_x", int'(x), 0);
        tick();
        chk("hs_reload_x", int'(x), 21);
        chk("hs_reload_y", int'(y), 0);
        chk("acq_locked", int'(locked), 0);

        wait_lock("lock");

        // One full locked frame: tracking and data enable
        track("frame", HT * VT, dc);
        chk("de_count", dc, 192);
        chk("de_x15_y0", de_a, 1);
        chk("de_x16_y0", de_b, 0);
        chk("de_x0_y12", de_c, 0);
        chk("de_x15_y11", de_d, 1);

        // HS fall on line 4 delayed by 3 columns
        run_until("hsdel_a", 2, 0);
        del_line = 4;
        run_until("hsdel_b", 4, HE);
        chk("hsdel_pre_err", int'(sync_err), 0);
        chk("hsdel_pre_lock", int'(locked), 1);
        tick();
        chk("hsdel_err", int'(sync_err), 1);
        chk("hsdel_unlock", int'(locked), 0);
        chk("hsdel_x_free", int'(x), 21);
        run_until("hsdel_c", 4, HE + 3);
        tick();
        chk("hsdel_late_reload", int'(x), 21);
        wait_lock("relock_hs");
        track("post_hs", 100, dc);

        // One VS pulse suppressed
        run_until("vsup_a", 2, 0);
        vs_sup = 1'b1;
        run_until("vsup_b", VE, 0);
        chk("vsup_pre_lock", int'(locked), 1);
        chk("vsup_pre_err", int'(sync_err), 0);
        tick();
        chk("vsup_err", int'(sync_err), 1);
        chk("vsup_unlock", int'(locked), 0);
        tick();
        chk("vsup_err_one_cycle", int'(sync_err), 0);
        wait_lock("relock_vs");
        track("post_vs", 100, dc);

        // Asynchronous reset pulse while locked at x=10, y=5
        run_until("rst_a", 5, 10);
        chk("pre_rst_x", int'(x), 10);
        chk("pre_rst_y", int'(y), 5);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_x", int'(x), 0);
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_de", int'(de), 0);
        tick();
        RST = 1'b0;
        chk("rst_cycle_x", int'(x), 0);
        tick();
        chk("rst_release_x", int'(x), 0);
        chk("rst_release_lock", int'(locked), 0);
        wait_lock("relock_rst");
        track("post_rst", 100, dc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_decoder.md
VGA_TIMING_DECODER -- requirements
Module: vga_timing_decoder

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_TOTAL, default 800, pixels per line.
REQ-004 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-005 Parameter V_FP, default 10, vertical front porch in lines.
REQ-006 Parameter V_TOTAL, default 525, lines per frame.
REQ-007 CLK  input  1  pixel clock; all logic on rising edge.
REQ-008 RST  input  1  reset, asynchronous, active-high.
REQ-009 HS  input  1  horizontal sync, active-low, synchronous to CLK.
REQ-010 VS  input  1  vertical sync, active-low, synchronous to CLK, changes only at line start.
REQ-011 x  output  10  recovered pixel column, registered.
REQ-012 y  output  10  recovered line number, registered.
REQ-013 de  output  1  data enable: locked and x < H_VISIBLE and y < V_VISIBLE.
REQ-014 locked  output  1  high while timing is tracked without error.
REQ-015 sync_err  output  1  one-cycle pulse on any sync mismatch or missing edge.

Function
REQ-016 The block SHALL register HS and VS once per cycle (hs_d, vs_d). HS fall = hs_d==1 && HS==0. VS fall = vs_d==1 && VS==0.
REQ-017 The block SHALL hold a free-running hcnt (0..H_TOTAL-1, wrap to 0) and vcnt, which increments when hcnt==H_TOTAL-1 and wraps V_TOTAL-1 -> 0. x=hcnt, y=vcnt.
REQ-018 HS reload: on an HS fall cycle that is accepted as a reload, hcnt SHALL load H_VISIBLE+H_FP+1 (657), so that x equals the source column from the next cycle onward.
REQ-019 VS reload: on a VS fall cycle that is accepted as a reload, vcnt SHALL load V_VISIBLE+V_FP (490). A reload takes priority over the increment in REQ-017.
REQ-020 FSM states SHALL be SEARCH, ACQUIRE and LOCKED, with SEARCH as the reset state.
REQ-021 SEARCH: on the first HS fall, the block SHALL reload hcnt and go to ACQUIRE with vs_seen=0. VS falls are ignored in SEARCH.
REQ-022 ACQUIRE, HS fall:
 - hcnt==656: no action.
 - hcnt!=656: reload hcnt, clear vs_seen, pulse sync_err.
REQ-023 ACQUIRE, VS fall:
 - vs_seen==0: reload vcnt, set vs_seen.
 - vs_seen==1, vcnt==490 and hcnt==0: go to LOCKED.
 - otherwise: reload vcnt and pulse sync_err.
REQ-024 LOCKED: counters SHALL freewheel. An error is any of:
 - HS fall with hcnt!=656;
 - hcnt==656 with no HS fall;
 - VS fall with (vcnt!=490 or hcnt!=0);
 - vcnt==490 and hcnt==0 with no VS fall.
REQ-025 On an error in LOCKED, the block SHALL pulse sync_err, deassert locked from the next cycle, and go to ACQUIRE with vs_seen=0. If the error cycle holds an HS fall, that fall reloads hcnt.
REQ-026 locked SHALL be a register that is 1 exactly while state==LOCKED, with zero-cycle latency after the state register.
REQ-027 de SHALL be combinational from locked, x and y. de SHALL be 0 outside LOCKED.
REQ-028 Simultaneous HS fall and VS fall SHALL both be evaluated in the same cycle. An error from either SHALL take effect.
REQ-029 All compares SHALL be unsigned 10-bit. No counter SHALL exceed H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-030 When RST is high, the block SHALL set:
 - state=SEARCH;
 - hcnt=0, vcnt=0;
 - hs_d=0, vs_d=0, so that no false edge is seen when RST releases;
 - vs_seen=0;
 - locked=0, sync_err=0;
 - so x=0, y=0, de=0.
REQ-031 RST asserted mid-frame SHALL abort lock at once. After release, reacquisition SHALL need the full sequence again.

Verification
REQ-032 Drive from a reference 800x525 generator (HS low at columns 656-751, VS low on lines 490-491). Required: locked rises on the cycle after the second VS fall, and thereafter x,y match the generator column and line every cycle.
REQ-033 Locked, then delay one HS fall by 3 cycles. Required: sync_err pulses at hcnt==656, locked falls, hcnt reloads to 657 on the late edge, and relock follows two frames later.
REQ-034 Locked, then suppress VS for one frame. Required: sync_err pulses at vcnt==490 and hcnt==0, and the state goes to ACQUIRE.
REQ-035 Locked, check de over one frame. Required: de high for exactly 640x480=307200 cycles, low at x=640 and at y=480.
REQ-036 Release RST with HS held low. Required: no reload until HS goes high and then falls, and x=0, y=0 meanwhile.
REQ-037 Assert RST for 1 cycle while locked at x=100, y=200. Required: outputs go to zero asynchronously, and locked reasserts only after two valid VS falls.
